flag_unit: RTL
==============

// Module: flag_unit
// PURPOSE
// - Parametrised status-flag register for the accumulator datapath; next generation of the 3-bit Z/C/S flag block.
// - Adds overflow flag V, carry capture from ALU or accumulator with one-cycle deferred sampling, and direct flag writes.
// - Adds a LIFO flag stack so interrupt entry/return can save and restore flags.
// - Sits beside the accumulator; flags[] feeds branch-condition logic.
// PARAMETERS
// - DATA_W       16  accumulator width; Z/S are derived from acc_value[DATA_W-1:0]
// - STACK_DEPTH  4   flag-stack entries (>=1); pointer width = $clog2(STACK_DEPTH+1)
// PORTS
// - clk            in   1       single clock, rising edge
// - rst_n          in   1       asynchronous, active-low reset
// - acc_value      in   DATA_W  current accumulator output
// - acc_upd        in   1       refresh Z and S from acc_value this edge
// - alu_op         in   1       ALU op issued; arm carry/overflow capture from ALU
// - alu_c          in   1       ALU carry (sampled in the cycle after alu_op)
// - alu_v          in   1       ALU signed overflow (sampled with alu_c)
// - a_op           in   1       accumulator shift/rotate op; arm carry capture from acc
// - a_c            in   1       accumulator carry-out (sampled in the cycle after a_op)
// - flag_wr        in   1       direct write of all flags
// - flag_wdata     in   4       value for flag_wr
// - push           in   1       save current flags onto stack
// - pop            in   1       restore flags from stack top
// - flags          out  4       {V,S,C,Z}: [0]=Z [1]=C [2]=S [3]=V
// - stack_full     out  1       stack holds STACK_DEPTH entries
// - stack_empty    out  1       stack holds 0 entries
// - stack_err      out  1       sticky: push when full or pop when empty
// BEHAVIOUR
// - Reset (async, rst_n=0): flags=4'b0001 (Z=1), pending state cleared, stack pointer=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
// - All outputs are registered; every update becomes visible one edge after its cause.
// - Pending capture, two-stage:
//   - Edge N with alu_op=1 sets pend_alu. alu_op has priority over a_op; a_op alone sets pend_a.
//   - Edge N+1 with pend_alu: C<=alu_c and V<=alu_v. With pend_a: C<=a_c, V unchanged. The pending bit clears.
//   - An op strobe arriving while a pending bit is set re-arms it at the same edge (back-to-back ops capture every cycle).
// - acc_upd=1: Z<=(acc_value==0), S<=acc_value[DATA_W-1] at the same edge. Independent of C/V capture.
// - Per-edge priority for flags: pop (valid) > flag_wr > {pending C/V capture, acc_upd}.
//   - Lower-priority updates in that cycle are discarded. Pending bits still clear and re-arm normally.
// - push (not full, pop=0): stack[ptr]<=flags (value before this edge's update), ptr++.
// - pop (not empty, push=0): flags<=stack[ptr-1], ptr--.
// - push and pop in the same cycle: both ignored, stack_err unaffected.
// - Push when full or pop when empty: stack and flags unchanged by that request; stack_err<=1.
//   - stack_err clears only on reset.
// - stack_full / stack_empty are decoded from the registered pointer.
// CONFIGURATION
// - FLAG_STACK_EN defined: stack, push/pop and stack_err are implemented as above.
// - FLAG_STACK_EN undefined: no stack storage. push/pop are ignored; stack_full=0, stack_empty=1, stack_err=0 constant. All other behaviour is identical.
// TESTING
// 1. Reset, then hold rst_n=0 mid-run -> flags=4'b0001, stack_empty=1, stack_err=0 immediately (async).
// 2. acc_upd with acc_value=16'h8000 -> next cycle Z=0,S=1. With 16'h0000 -> Z=1,S=0.
// 3. alu_op at N; alu_c=1, alu_v=1 at N+1 -> C=1,V=1 after edge N+1 (not after N). a_op then a_c=0 -> C=0, V stays 1.
// 4. alu_op and a_op together at N; alu_c=0, a_c=1 at N+1 -> C=0 (ALU wins). flag_wr=4'hA with pending capture -> flags=4'hA.
// 5. Push 4 distinct values with DEPTH=4 -> stack_full=1. 5th push -> stack_err=1, top unchanged. Four pops restore in LIFO order, then stack_empty=1.
// 6. push+pop same cycle -> ptr and flags unchanged. Pop on empty -> stack_err=1, flags unchanged. Without FLAG_STACK_EN: push/pop are no-ops, stack_empty=1.

Source files
------------

// File: rtl/flag_unit.sv
// Z/C/S/V status flags with deferred carry/overflow capture and an optional LIFO flag stack.
// The stack is built only when FLAG_STACK_EN is defined; otherwise push/pop are ignored.
module flag_unit #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] acc_value,
    input  logic              acc_upd,
    input  logic              alu_op,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              a_op,
    input  logic              a_c,
    input  logic              flag_wr,
    input  logic [3:0]        flag_wdata,
    input  logic              push,
    input  logic              pop,
    output logic [3:0]        flags,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int PW = $clog2(STACK_DEPTH + 1);

    localparam int FZ = 0;
    localparam int FC = 1;
    localparam int FS = 2;
    localparam int FV = 3;

    logic       r_pend_alu;
    logic       r_pend_a;
    logic [3:0] r_flags;

    logic       w_pend_alu_nxt;
    logic       w_pend_a_nxt;
    logic [3:0] w_cap;
    logic [3:0] w_flags_nxt;
    logic       w_pop_ok;
    logic [3:0] w_top;

    // A new op strobe always re-arms, so back-to-back ops capture every cycle.
    always_comb begin
        w_pend_alu_nxt = 1'b0;
        w_pend_a_nxt   = 1'b0;
        if (alu_op) begin
            w_pend_alu_nxt = 1'b1;
        end else if (a_op) begin
            w_pend_a_nxt = 1'b1;
        end
    end

    always_comb begin
        w_cap = r_flags;
        if (r_pend_alu) begin
            w_cap[FC] = alu_c;
            w_cap[FV] = alu_v;
        end else if (r_pend_a) begin
            w_cap[FC] = a_c;
        end
        if (acc_upd) begin
            w_cap[FZ] = (acc_value == '0);
            w_cap[FS] = acc_value[DATA_W-1];
        end
    end

    always_comb begin
        w_flags_nxt = w_cap;
        if (w_pop_ok) begin
            w_flags_nxt = w_top;
        end else if (flag_wr) begin
            w_flags_nxt = flag_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_alu <= 1'b0;
            r_pend_a   <= 1'b0;
            r_flags    <= 4'b0001;
        end else begin
            r_pend_alu <= w_pend_alu_nxt;
            r_pend_a   <= w_pend_a_nxt;
            r_flags    <= w_flags_nxt;
        end
    end

    assign flags = r_flags;

`ifdef FLAG_STACK_EN

    logic [PW-1:0] r_ptr;
    logic          r_err;
    logic [3:0]    r_stack [STACK_DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_err_set;

    assign w_full    = (r_ptr == PW'(STACK_DEPTH));
    assign w_empty   = (r_ptr == '0);
    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;
    assign w_err_set = (push & ~pop & w_full) | (pop & ~push & w_empty);

    always_comb begin
        w_top = 4'b0000;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_ptr == PW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end else if (w_pop_ok) begin
                r_ptr <= r_ptr - 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Pushed value is the flags before this edge's own update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= 4'b0000;
            end
        end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (w_push_ok && (r_ptr == PW'(i))) begin
                    r_stack[i] <= r_flags;
                end
            end
        end
    end

    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign stack_err   = r_err;

`else

    logic w_unused;

    assign w_unused    = &{1'b0, push, pop};
    assign w_pop_ok    = 1'b0;
    assign w_top       = 4'b0000;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;

`endif

endmodule
